jt12_dac_rx: RTL and testbench

- Receiving end of the per-channel multiplexed DAC stream that the operator accumulator produces (`mux_left`/`mux_right` plus a per-slot strobe).
- Demultiplexes the stream into six channel slots and snapshots each complete frame.
- Sums the six slots per side into 12-bit left/right samples.
- Serialises those samples to an external I2S DAC.
- Sits between the FM core output and the board-level audio DAC pins.

---
 rtl/jt12_dac_rx.sv | 233 +++++++++++++++++++++++
 tb/tb_jt12_dac_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_dac_rx.sv
// jt12_dac_rx: receives the per-channel multiplexed DAC stream, demultiplexes
// it into channel slots, sums each complete frame into 12-bit left/right
// samples and serialises them as 32-bit I2S frames for an external DAC.
module jt12_dac_rx #(
    parameter int CHANNELS = 6,
    parameter int DIV      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [8:0] mux_left,
    input  logic signed [8:0] mux_right,
    input  logic              mux_sample,
    input  logic              ch_sync,
    output logic [11:0]       left,
    output logic [11:0]       right,
    output logic              sample,
    output logic              sync_err,
    output logic              bclk,
    output logic              lrck,
    output logic              sdata
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW = $clog2(DIV);
    localparam logic [SW-1:0] LAST    = SW'(CHANNELS - 1);
    localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Live slots, the bank being summed, and a bank waiting behind it
    logic signed [8:0] live_l_r   [CHANNELS];
    logic signed [8:0] live_r_r   [CHANNELS];
    logic signed [8:0] shadow_l_r [CHANNELS];
    logic signed [8:0] shadow_r_r [CHANNELS];
    logic signed [8:0] pend_l_r   [CHANNELS];
    logic signed [8:0] pend_r_r   [CHANNELS];
    logic signed [8:0] snap_l_s   [CHANNELS];
    logic signed [8:0] snap_r_s   [CHANNELS];

    logic [SW-1:0] slot_r;
    logic          synced_r;
    logic          sync_err_r;
    logic          wr_en_s;
    logic [SW-1:0] wr_idx_s;
    logic          err_s;
    logic          frame_done_s;

    logic [1:0]    state_r;
    logic [SW-1:0] idx_r;
    logic          pend_vld_r;
    logic [11:0]   acc_l_r;
    logic [11:0]   acc_r_r;
    logic [11:0]   left_r;
    logic [11:0]   right_r;
    logic          sample_r;

    logic [DW-1:0] div_r;
    logic          bclk_r;
    logic          lrck_r;
    logic          sdata_r;
    logic [4:0]    bit_r;
    logic [4:0]    bit_nx_s;
    logic [31:0]   shreg_r;

    // Decode the incoming strobe into a slot write or a framing error
    always_comb begin
        wr_en_s  = 1'b0;
        wr_idx_s = {SW{1'b0}};
        err_s    = 1'b0;
        if (mux_sample) begin
            if (ch_sync) begin
                wr_en_s = 1'b1;
            end else if (synced_r && (slot_r != LAST)) begin
                wr_en_s  = 1'b1;
                wr_idx_s = slot_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                err_s = 1'b1;
            end
        end else begin
            err_s = 1'b0;
        end
        frame_done_s = wr_en_s && (wr_idx_s == LAST);
    end

    // Snapshot view of the live bank including the value being written now
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en_s && (wr_idx_s == SW'(i))) begin
                snap_l_s[i] = mux_left;
                snap_r_s[i] = mux_right;
            end else begin
                snap_l_s[i] = live_l_r[i];
                snap_r_s[i] = live_r_r[i];
            end
        end
    end

    // Slot tracking: live bank writes, sync state and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                live_l_r[i] <= 9'sd0;
                live_r_r[i] <= 9'sd0;
            end
            slot_r     <= {SW{1'b0}};
            synced_r   <= 1'b0;
            sync_err_r <= 1'b0;
        end else if (wr_en_s) begin
            live_l_r[wr_idx_s] <= mux_left;
            live_r_r[wr_idx_s] <= mux_right;
            slot_r             <= wr_idx_s;
            synced_r           <= 1'b1;
        end else if (err_s) begin
            synced_r   <= 1'b0;
            sync_err_r <= 1'b1;
        end
    end

    // Summation FSM: snapshot, accumulate one slot per cycle, publish the sums
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_l_r[i] <= 9'sd0;
                shadow_r_r[i] <= 9'sd0;
                pend_l_r[i]   <= 9'sd0;
                pend_r_r[i]   <= 9'sd0;
            end
            state_r    <= IDLE;
            idx_r      <= {SW{1'b0}};
            pend_vld_r <= 1'b0;
            acc_l_r    <= 12'd0;
            acc_r_r    <= 12'd0;
            left_r     <= 12'd0;
            right_r    <= 12'd0;
            sample_r   <= 1'b0;
        end else begin
            sample_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (frame_done_s) begin
                        shadow_l_r <= snap_l_s;
                        shadow_r_r <= snap_r_s;
                        acc_l_r    <= 12'd0;
                        acc_r_r    <= 12'd0;
                        idx_r      <= {SW{1'b0}};
                        state_r    <= SUM;
                    end
                end
                SUM: begin
                    acc_l_r <= acc_l_r + {{3{shadow_l_r[idx_r][8]}}, shadow_l_r[idx_r]};
                    acc_r_r <= acc_r_r + {{3{shadow_r_r[idx_r][8]}}, shadow_r_r[idx_r]};
                    if (idx_r == LAST) begin
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + {{(SW-1){1'b0}}, 1'b1};
                    end
                    // A frame finishing mid-sum waits; only the newest is kept
                    if (frame_done_s) begin
                        pend_l_r   <= snap_l_s;
                        pend_r_r   <= snap_r_s;
                        pend_vld_r <= 1'b1;
                    end
                end
                DONE: begin
                    left_r   <= acc_l_r;
                    right_r  <= acc_r_r;
                    sample_r <= 1'b1;
                    acc_l_r  <= 12'd0;
                    acc_r_r  <= 12'd0;
                    idx_r    <= {SW{1'b0}};
                    if (frame_done_s) begin
                        shadow_l_r <= snap_l_s;
                        shadow_r_r <= snap_r_s;
                        pend_vld_r <= 1'b0;
                        state_r    <= SUM;
                    end else if (pend_vld_r) begin
                        shadow_l_r <= pend_l_r;
                        shadow_r_r <= pend_r_r;
                        pend_vld_r <= 1'b0;
                        state_r    <= SUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Next bit position within the 32-bit I2S frame
    always_comb begin
        bit_nx_s = bit_r + 5'd1;
    end

    // I2S serialiser: bit clock divider, word select and MSB-first shifter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r   <= {DW{1'b0}};
            bclk_r  <= 1'b0;
            lrck_r  <= 1'b0;
            sdata_r <= 1'b0;
            bit_r   <= 5'd0;
            shreg_r <= 32'd0;
        end else if (div_r == DIV_TOP) begin
            div_r  <= {DW{1'b0}};
            bclk_r <= ~bclk_r;
            if (bclk_r) begin
                bit_r   <= bit_nx_s;
                lrck_r  <= bit_nx_s[4];
                sdata_r <= shreg_r[31];
                if (bit_r == 5'd31) begin
                    shreg_r <= {left_r, 4'b0000, right_r, 4'b0000};
                end else begin
                    shreg_r <= {shreg_r[30:0], 1'b0};
                end
            end
        end else begin
            div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    assign left     = left_r;
    assign right    = right_r;
    assign sample   = sample_r;
    assign sync_err = sync_err_r;
    assign bclk     = bclk_r;
    assign lrck     = lrck_r;
    assign sdata    = sdata_r;

endmodule

// File: tb/tb_jt12_dac_rx.sv
// tb_jt12_dac_rx: directed vectors for jt12_dac_rx with hand-computed sums,
// I2S word decoding and framing-error scenarios.
module tb_jt12_dac_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  mux_left;
    logic [8:0]  mux_right;
    logic        mux_sample;
    logic        ch_sync;
    logic [11:0] left;
    logic [11:0] right;
    logic        sample;
    logic        sync_err;
    logic        bclk;
    logic        lrck;
    logic        sdata;

    int vec_cnt = 0;
    int err_cnt = 0;
    int sample_cnt = 0;
    int word_cnt = 0;
    logic [31:0] dec_sh = 32'd0;
    logic [31:0] word = 32'd0;
    logic        prev_lr = 1'b0;

    logic [8:0] vl [6];
    logic [8:0] vr [6];

    jt12_dac_rx #(.CHANNELS(6), .DIV(4)) dut (
        .clk(clk), .rst(rst),
        .mux_left(mux_left), .mux_right(mux_right),
        .mux_sample(mux_sample), .ch_sync(ch_sync),
        .left(left), .right(right), .sample(sample), .sync_err(sync_err),
        .bclk(bclk), .lrck(lrck), .sdata(sdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample) sample_cnt <= sample_cnt + 1;
    end

    // I2S receiver: a word is complete at the bclk rise where lrck returns low
    always @(posedge bclk) begin
        dec_sh  <= {dec_sh[30:0], sdata};
        prev_lr <= lrck;
        if (prev_lr && !lrck) begin
            word     <= {dec_sh[30:0], sdata};
            word_cnt <= word_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [8:0] l, input logic [8:0] r, input logic s);
        @(negedge clk);
        mux_left = l; mux_right = r; ch_sync = s; mux_sample = 1'b1;
        @(posedge clk);
        #1;
        mux_sample = 1'b0; ch_sync = 1'b0;
    endtask

    task automatic send_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (3) @(posedge clk);
            strobe(vl[i], vr[i], (i == 0));
        end
    endtask

    task automatic wait_sample(output int n);
        n = 31;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (sample) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [11:0] el, input logic [11:0] er);
        int n;
        send_strobes(6);
        wait_sample(n);
        check({tag, "_lat"}, n, 7);
        check({tag, "_left"}, {20'd0, left}, {20'd0, el});
        check({tag, "_right"}, {20'd0, right}, {20'd0, er});
    endtask

    task automatic wait_word(output logic [31:0] w);
        int c0;
        c0 = word_cnt;
        w = 32'hxxxxxxxx;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            #1;
            if (word_cnt != c0) begin
                w = word;
                break;
            end
        end
    endtask

    task automatic measure_period(input logic which, output int per);
        int   t0;
        logic prv;
        logic cur;
        t0  = -1;
        per = -1;
        prv = which ? lrck : bclk;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            #1;
            cur = which ? lrck : bclk;
            if (cur && !prv) begin
                if (t0 < 0) begin
                    t0 = i;
                end else begin
                    per = i - t0;
                    break;
                end
            end
            prv = cur;
        end
    endtask

    task automatic set_nominal();
        vl[0] = 9'd10;  vl[1] = 9'd20;  vl[2] = 9'd30;
        vl[3] = -9'sd5; vl[4] = -9'sd100; vl[5] = 9'd255;
        for (int i = 0; i < 6; i++) vr[i] = -9'sd256;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_left"}, {20'd0, left}, 32'd0);
        check({tag, "_right"}, {20'd0, right}, 32'd0);
        check({tag, "_sample"}, {31'd0, sample}, 32'd0);
        check({tag, "_sync_err"}, {31'd0, sync_err}, 32'd0);
        check({tag, "_bclk"}, {31'd0, bclk}, 32'd0);
        check({tag, "_lrck"}, {31'd0, lrck}, 32'd0);
        check({tag, "_sdata"}, {31'd0, sdata}, 32'd0);
    endtask

    initial begin
        int          n;
        int          c0;
        logic [31:0] w;

        rst = 1'b0; mux_left = 9'd0; mux_right = 9'd0; mux_sample = 1'b0; ch_sync = 1'b0;
        #23;
        check_all_zero("reset");
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Nominal frame
        set_nominal();
        run_frame("nominal", 12'h0D2, 12'hA00);
        check("nominal_sync_err", {31'd0, sync_err}, 32'd0);

        // Serial timing and word contents
        measure_period(1'b0, n);
        check("bclk_period", n, 8);
        measure_period(1'b1, n);
        check("lrck_period", n, 256);
        wait_word(w);
        wait_word(w);
        check("i2s_left_word", {16'd0, w[31:16]}, 32'h0000_0D20);
        check("i2s_right_word", {16'd0, w[15:0]}, 32'h0000_A000);

        // Mid-word update: word in flight keeps the old sums
        wait_word(w);
        for (int i = 0; i < 6; i++) begin
            vl[i] = 9'(i + 1);
            vr[i] = -9'(i + 1);
        end
        run_frame("midword", 12'h015, 12'hFEB);
        wait_word(w);
        check("midword_inflight", w, 32'h0D20_A000);
        wait_word(w);
        check("midword_next", w, 32'h0150_FEB0);

        // Overlap: next slot-0 strobe lands during SUM of the previous frame
        set_nominal();
        send_strobes(6);
        repeat (3) @(posedge clk);
        strobe(9'd6, 9'd7, 1'b1);
        wait_sample(n);
        check("overlap_a_lat", n, 3);
        check("overlap_a_left", {20'd0, left}, 32'h0000_00D2);
        check("overlap_a_right", {20'd0, right}, 32'h0000_0A00);
        for (int i = 1; i < 6; i++) begin
            repeat (3) @(posedge clk);
            strobe(9'(i), 9'd7, 1'b0);
        end
        wait_sample(n);
        check("overlap_b_lat", n, 7);
        check("overlap_b_left", {20'd0, left}, 32'h0000_0015);
        check("overlap_b_right", {20'd0, right}, 32'h0000_002A);
        check("overlap_sync_err", {31'd0, sync_err}, 32'd0);

        // Seventh strobe without ch_sync
        repeat (3) @(posedge clk);
        c0 = sample_cnt;
        strobe(9'd100, 9'd100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("extra_sync_err", {31'd0, sync_err}, 32'd1);
        repeat (15) @(posedge clk);
        check("extra_no_sample", sample_cnt, c0);
        check("extra_left_kept", {20'd0, left}, 32'h0000_0015);
        set_nominal();
        run_frame("after_extra", 12'h0D2, 12'hA00);
        check("after_extra_sticky", {31'd0, sync_err}, 32'd1);

        // Strobe before any ch_sync
        #2; rst = 1'b0; #3; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("clr_sync_err", {31'd0, sync_err}, 32'd0);
        strobe(9'd50, 9'd50, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("nosync_sync_err", {31'd0, sync_err}, 32'd1);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            vl[i] = 9'd255;
            vr[i] = 9'd0;
        end
        vr[5] = -9'sd1;
        run_frame("after_nosync", 12'h5FA, 12'hFFF);
        check("after_nosync_sticky", {31'd0, sync_err}, 32'd1);

        // Reset in the middle of a summation
        repeat (3) @(posedge clk);
        set_nominal();
        send_strobes(6);
        repeat (2) @(posedge clk);
        c0 = sample_cnt;
        #2; rst = 1'b0; #1;
        check_all_zero("midsum_reset");
        #4; rst = 1'b1;
        repeat (20) @(posedge clk);
        check("midsum_no_sample", sample_cnt, c0);
        send_strobes(5);
        repeat (15) @(posedge clk);
        check("partial_no_sample", sample_cnt, c0);
        run_frame("post_reset", 12'h0D2, 12'hA00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
